irq_ctrl: RTL and testbench

Interrupt controller placed in front of the CP0 block. It collects up to 8 external interrupt sources and applies a software-writable mask. A fixed-priority scheduler picks one source and sends it to CP0 as a single one-cycle request pulse. The block then holds the serviced source id and stays busy until the pipeline reports ERET, so at most one interrupt is in service at a time.

---
 rtl/irq_ctrl_pkg.sv | 18 +
 rtl/irq_ctrl_prio_enc.sv | 26 ++
 rtl/irq_ctrl.sv | 96 +++++++++
 tb/tb_irq_ctrl.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM states, id width
// and the bit layout of the cause status word.
package irq_ctrl_pkg;

   localparam int unsigned ID_W = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SIGNAL  = 2'd1,
      SERVICE = 2'd2
   } irq_state_e;

   localparam int unsigned CAUSE_BUSY_BIT = 31;
   localparam int unsigned CAUSE_PEND_LSB = 8;
   localparam int unsigned CAUSE_ID_LSB   = 2;
   localparam int unsigned CAUSE_ID_W     = 5;

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-wins priority encoder: request vector to source index plus valid.
module irq_prio_enc
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC = 8
) (
   input  logic [N_SRC-1:0] req_i,
   output logic [ID_W-1:0]  idx_o,
   output logic             valid_o
);

   logic found;

   always_comb begin
      idx_o = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
         if (req_i[i] && !found) begin
            idx_o = ID_W'(i);
            found = 1'b1;
         end
      end
      valid_o = found;
   end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller in front of CP0: masks and latches sources, grants one
// at a time by fixed priority and stays busy until ERET.
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int unsigned N_SRC     = 8,
   parameter logic [7:0]  EDGE_MASK = 8'hFF,
   parameter logic [7:0]  MASK_RST  = 8'hFF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_SRC-1:0] irq_src,
   input  logic             mask_we,
   input  logic [N_SRC-1:0] mask_wdata,
   input  logic             ir_en,
   input  logic             eret,
   output logic             ir_out,
   output logic [2:0]       irq_id,
   output logic             busy,
   output logic [N_SRC-1:0] pending,
   output logic [31:0]      cause
);

   localparam logic [N_SRC-1:0] EDGE_M = EDGE_MASK[N_SRC-1:0];
   localparam logic [N_SRC-1:0] MASK_R = MASK_RST[N_SRC-1:0];

   irq_state_e       state_q, state_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [N_SRC-1:0] prev_q;
   logic [N_SRC-1:0] pend_q, pend_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] eligible, edge_det, clr;
   logic [ID_W-1:0]  grant_idx;
   logic             grant_vld;

   assign eligible = pend_q & mask_q;
   assign edge_det = irq_src & ~prev_q;

   irq_prio_enc #(.N_SRC(N_SRC)) u_prio (
      .req_i   (eligible),
      .idx_o   (grant_idx),
      .valid_o (grant_vld)
   );

   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      clr     = '0;
      case (state_q)
         IDLE: begin
            if (ir_en && grant_vld) begin
               id_d    = grant_idx;
               clr     = N_SRC'(1) << grant_idx;
               state_d = SIGNAL;
            end
         end
         SIGNAL:  state_d = SERVICE;
         SERVICE: if (eret) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Edge bits: a fresh edge overrides a same-cycle grant clear.
   // Level bits simply track the source one cycle late.
   assign pend_d = (EDGE_M & (edge_det | (pend_q & ~clr))) | (~EDGE_M & irq_src);
   assign mask_d = mask_we ? mask_wdata : mask_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= '0;
         prev_q  <= '0;
         pend_q  <= '0;
         mask_q  <= MASK_R;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         prev_q  <= irq_src;
         pend_q  <= pend_d;
         mask_q  <= mask_d;
      end
   end

   assign ir_out  = (state_q == SIGNAL);
   assign busy    = (state_q != IDLE);
   assign irq_id  = id_q;
   assign pending = pend_q;

   always_comb begin
      cause                               = '0;
      cause[CAUSE_BUSY_BIT]               = busy;
      cause[CAUSE_PEND_LSB +: N_SRC]      = pend_q;
      cause[CAUSE_ID_LSB +: CAUSE_ID_W]   = CAUSE_ID_W'(id_q);
   end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed vector bench for irq_ctrl with source 0 configured level-sensitive.
module tb_irq_ctrl;

   logic        clk;
   logic        rst;
   logic [7:0]  irq_src;
   logic        mask_we;
   logic [7:0]  mask_wdata;
   logic        ir_en;
   logic        eret;
   logic        ir_out;
   logic [2:0]  irq_id;
   logic        busy;
   logic [7:0]  pending;
   logic [31:0] cause;

   int n_checks = 0;
   int n_fail   = 0;

   irq_ctrl #(.N_SRC(8), .EDGE_MASK(8'hFE), .MASK_RST(8'hFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .irq_src    (irq_src),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .ir_en      (ir_en),
      .eret       (eret),
      .ir_out     (ir_out),
      .irq_id     (irq_id),
      .busy       (busy),
      .pending    (pending),
      .cause      (cause)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic [7:0] src;
      logic       mwe;
      logic [7:0] mdata;
      logic       en;
      logic       eret;
      logic       e_ir;
      logic       e_busy;
      logic [2:0] e_id;
      logic [7:0] e_pend;
   } vec_t;

   vec_t vecs[$];

   task automatic addv(input logic r, input logic [7:0] s, input logic mw, input logic [7:0] md,
                       input logic en, input logic er, input logic e_ir, input logic e_b,
                       input logic [2:0] e_id, input logic [7:0] e_p);
      vec_t v;
      v.rst = r; v.src = s; v.mwe = mw; v.mdata = md; v.en = en; v.eret = er;
      v.e_ir = e_ir; v.e_busy = e_b; v.e_id = e_id; v.e_pend = e_p;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [7:0] s, input logic mw, input logic [7:0] md,
                        input logic en, input logic er);
      rst = r; irq_src = s; mask_we = mw; mask_wdata = md; ir_en = en; eret = er;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic e_ir, input logic e_b,
                             input logic [2:0] e_id, input logic [7:0] e_p);
      logic [31:0] ec;
      ec = {e_b, 15'b0, e_p, 1'b0, 2'b00, e_id, 2'b00};
      check({tag, ".ir_out"},  32'(ir_out),  32'(e_ir));
      check({tag, ".busy"},    32'(busy),    32'(e_b));
      check({tag, ".irq_id"},  32'(irq_id),  32'(e_id));
      check({tag, ".pending"}, 32'(pending), 32'(e_p));
      check({tag, ".cause"},   cause,        ec);
   endtask

   initial begin
      int ir_cnt;
      rst = 1'b1; irq_src = '0; mask_we = 1'b0; mask_wdata = '0; ir_en = 1'b1; eret = 1'b0;

      //   rst src  mwe mdata en eret | ir busy id pend
      addv(1, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00); // reset
      addv(0, 8'h04, 0, 8'h00, 1, 0,  0, 0, 0, 8'h04); // single edge
      addv(0, 8'h04, 0, 8'h00, 1, 0,  1, 1, 2, 8'h00);
      addv(0, 8'h04, 0, 8'h00, 1, 0,  0, 1, 2, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 2, 8'h00);
      addv(0, 8'h22, 0, 8'h00, 1, 0,  0, 0, 2, 8'h22); // priority 1 vs 5
      addv(0, 8'h22, 0, 8'h00, 1, 0,  1, 1, 1, 8'h20);
      addv(0, 8'h22, 0, 8'h00, 1, 0,  0, 1, 1, 8'h20);
      addv(0, 8'h22, 0, 8'h00, 1, 1,  0, 0, 1, 8'h20);
      addv(0, 8'h22, 0, 8'h00, 1, 0,  1, 1, 5, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 5, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 5, 8'h00);
      addv(0, 8'h00, 1, 8'hFB, 1, 0,  0, 0, 5, 8'h00); // mask source 2
      addv(0, 8'h04, 0, 8'h00, 1, 0,  0, 0, 5, 8'h04);
      addv(0, 8'h04, 0, 8'h00, 1, 0,  0, 0, 5, 8'h04);
      addv(0, 8'h00, 1, 8'hFF, 1, 0,  0, 0, 5, 8'h04);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  1, 1, 2, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 2, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 2, 8'h00);
      addv(0, 8'h08, 0, 8'h00, 0, 0,  0, 0, 2, 8'h08); // ir_en low holds
      addv(0, 8'h08, 0, 8'h00, 0, 0,  0, 0, 2, 8'h08);
      addv(0, 8'h08, 0, 8'h00, 0, 0,  0, 0, 2, 8'h08);
      addv(0, 8'h08, 0, 8'h00, 1, 0,  1, 1, 3, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 3, 8'h00); // re-arm in service
      addv(0, 8'h08, 0, 8'h00, 1, 0,  0, 1, 3, 8'h08);
      addv(0, 8'h08, 0, 8'h00, 1, 0,  0, 1, 3, 8'h08);
      addv(0, 8'h08, 0, 8'h00, 1, 1,  0, 0, 3, 8'h08);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  1, 1, 3, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 3, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 3, 8'h00);
      addv(0, 8'h01, 0, 8'h00, 1, 0,  0, 0, 3, 8'h01); // level source 0
      addv(0, 8'h01, 0, 8'h00, 1, 0,  1, 1, 0, 8'h01);
      addv(0, 8'h01, 0, 8'h00, 1, 0,  0, 1, 0, 8'h01);
      addv(0, 8'h01, 0, 8'h00, 1, 1,  0, 0, 0, 8'h01);
      addv(0, 8'h01, 0, 8'h00, 1, 0,  1, 1, 0, 8'h01);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 0, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 0, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 1,  0, 0, 0, 8'h00); // eret in IDLE
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00);
      addv(0, 8'h10, 0, 8'h00, 1, 0,  0, 0, 0, 8'h10); // reset mid-service
      addv(0, 8'h10, 0, 8'h00, 1, 0,  1, 1, 4, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 1, 4, 8'h00);
      addv(0, 8'h10, 1, 8'h00, 1, 0,  0, 1, 4, 8'h10);
      addv(1, 8'h00, 1, 8'h00, 1, 1,  0, 0, 0, 8'h00);
      addv(0, 8'h00, 0, 8'h00, 1, 0,  0, 0, 0, 8'h00);
      addv(0, 8'h10, 0, 8'h00, 1, 0,  0, 0, 0, 8'h10);
      addv(0, 8'h10, 0, 8'h00, 1, 0,  1, 1, 4, 8'h00); // mask back to FF
      addv(0, 8'h10, 0, 8'h00, 1, 1,  0, 1, 4, 8'h00); // eret in SIGNAL
      addv(0, 8'h10, 0, 8'h00, 1, 0,  0, 1, 4, 8'h00);
      addv(0, 8'h10, 0, 8'h00, 1, 1,  0, 0, 4, 8'h00);

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].src, vecs[i].mwe, vecs[i].mdata, vecs[i].en, vecs[i].eret);
         expect_out($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_busy, vecs[i].e_id, vecs[i].e_pend);
      end

      // New edge coinciding with its own grant: pending bit survives.
      drive(0, 8'h00, 0, 8'h00, 0, 0); expect_out("sw.a", 0, 0, 4, 8'h00);
      drive(0, 8'h04, 0, 8'h00, 0, 0); expect_out("sw.b", 0, 0, 4, 8'h04);
      drive(0, 8'h00, 0, 8'h00, 0, 0); expect_out("sw.c", 0, 0, 4, 8'h04);
      drive(0, 8'h04, 0, 8'h00, 1, 0); expect_out("sw.d", 1, 1, 2, 8'h04);
      check("sw.cause", cause, 32'h8000_0408);
      drive(0, 8'h04, 0, 8'h00, 1, 0); expect_out("sw.e", 0, 1, 2, 8'h04);
      drive(0, 8'h04, 0, 8'h00, 1, 1); expect_out("sw.f", 0, 0, 2, 8'h04);
      drive(0, 8'h04, 0, 8'h00, 1, 0); expect_out("sw.g", 1, 1, 2, 8'h00);
      drive(0, 8'h00, 0, 8'h00, 1, 0); expect_out("sw.h", 0, 1, 2, 8'h00);
      drive(0, 8'h00, 0, 8'h00, 1, 1); expect_out("sw.i", 0, 0, 2, 8'h00);

      // One source, long service window: ir_out must pulse exactly once.
      ir_cnt = 0;
      drive(0, 8'h40, 0, 8'h00, 1, 0);
      for (int k = 0; k < 8; k++) begin
         drive(0, 8'h40, 0, 8'h00, 1, 0);
         if (ir_out) ir_cnt++;
      end
      check("pulse.count", 32'(ir_cnt), 32'd1);
      check("pulse.busy", 32'(busy), 32'd1);
      check("pulse.id", 32'(irq_id), 32'd6);
      drive(0, 8'h00, 0, 8'h00, 1, 1);
      check("pulse.release", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
